// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: datapath control codes,
// the 3-bit state encoding and a helper that classifies in-sequence states.
package control_sequencer_pkg;

    localparam logic [1:0] CODE_INIT = 2'b00;
    localparam logic [1:0] CODE_LOAD = 2'b01;
    localparam logic [1:0] CODE_OPA  = 2'b10;
    localparam logic [1:0] CODE_OPB  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } state_e;

    function automatic logic is_active(state_e s);
        return (s == ST_INIT) || (s == ST_LOAD) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/control_sequencer.sv
// Steps INIT -> LOAD -> n x RUN on a start request and presents one control
// code per cycle to the control-word decoder, with done/aborted pulses.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [CNT_W-1:0] n,
    input  logic             hold,
    input  logic             abort,
    output logic [1:0]       code,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Registered stall flag: hold is sampled at the edge and the frozen state
    // is then shown as not-valid, so no input reaches an output combinationally.
    logic             stall_q, stall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        stall_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d   = sel;
                    cnt_d   = n;
                    state_d = ST_INIT;
                end
            end
            ST_INIT, ST_LOAD, ST_RUN: begin
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (hold) begin
                    stall_d = 1'b1;
                end else if (state_q == ST_INIT) begin
                    state_d = ST_LOAD;
                end else if (state_q == ST_LOAD) begin
                    state_d = (cnt_q != CNT_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE, ST_ABORT: state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        code = CODE_INIT;
        case (state_q)
            ST_LOAD: code = CODE_LOAD;
            ST_RUN:  code = sel_q ? CODE_OPB : CODE_OPA;
            default: code = CODE_INIT;
        endcase
    end

    assign busy      = is_active(state_q);
    assign valid     = busy && !stall_q;
    assign done      = (state_q == ST_DONE);
    assign aborted   = (state_q == ST_ABORT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus hand-written
// sequences for reset-while-idle and asynchronous reset mid-RUN.
module tb_control_sequencer;

    typedef struct packed {
        logic       start;
        logic       sel;
        logic [3:0] n;
        logic       hold;
        logic       abort;
        logic [1:0] code;
        logic       valid;
        logic       busy;
        logic       done;
        logic       aborted;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic [3:0] n;
    logic       hold;
    logic       abort;
    logic [1:0] code;
    logic       valid;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] dbg_state;

    int vec_cnt;
    int err_cnt;
    vec_t vq[$];

    control_sequencer #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .n         (n),
        .hold      (hold),
        .abort     (abort),
        .code      (code),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic sl, input logic [3:0] nn,
                                input logic hd, input logic ab, input logic [1:0] cd,
                                input logic v, input logic b, input logic d, input logic a);
        vec_t r;
        r = '{st, sl, nn, hd, ab, cd, v, b, d, a};
        return r;
    endfunction

    task automatic check_out(input string name, input logic [1:0] e_code, input logic e_valid,
                             input logic e_busy, input logic e_done, input logic e_aborted);
        logic [5:0] act;
        logic [5:0] exp;
        act = {code, valid, busy, done, aborted};
        exp = {e_code, e_valid, e_busy, e_done, e_aborted};
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got code=%b valid=%b busy=%b done=%b aborted=%b, want code=%b valid=%b busy=%b done=%b aborted=%b",
                     name, act[5:4], act[3], act[2], act[1], act[0],
                     exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic [3:0] nn,
                         input logic hd, input logic ab);
        start = st;
        sel   = sl;
        n     = nn;
        hold  = hd;
        abort = ab;
    endtask

    // Inputs set before an edge; outputs checked #1 after that edge.
    task automatic step_check(input string name, input logic [1:0] e_code, input logic e_valid,
                              input logic e_busy, input logic e_done, input logic e_aborted);
        @(posedge clk);
        #1;
        check_out(name, e_code, e_valid, e_busy, e_done, e_aborted);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset then idle for 10 cycles.
        #2;
        check_out("reset_async", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_check("reset_hold", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        step_check("reset_release_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        //              st    sel   n      hold  abort code   v     b     d     a
        // Normal run: sel=0, n=3.
        vq.push_back(mk(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        // Zero count: sel=1, n=0 skips RUN.
        vq.push_back(mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        // Hold: sel=1, n=2, hold sampled on two edges during the first RUN cycle.
        vq.push_back(mk(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        // Abort: n=5, abort during the second RUN cycle.
        vq.push_back(mk(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        // start during ABORT is ignored.
        vq.push_back(mk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        // New sequence runs normally; start held high throughout is ignored while busy.
        vq.push_back(mk(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        // Back-to-back: start re-sampled in IDLE; abort in the same IDLE cycle loses.
        vq.push_back(mk(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
        // Hold in INIT, then abort overrides hold.
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        // Hold has no effect in ABORT or IDLE.
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (vq[i]) begin
            drive(vq[i].start, vq[i].sel, vq[i].n, vq[i].hold, vq[i].abort);
            step_check($sformatf("vec%0d", i), vq[i].code, vq[i].valid, vq[i].busy,
                       vq[i].done, vq[i].aborted);
        end

        // Asynchronous reset mid-RUN.
        drive(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        step_check("arst_init", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step_check("arst_load", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step_check("arst_run", 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst_immediate", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        step_check("arst_start_ignored_a", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step_check("arst_start_ignored_b", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step_check("arst_idle_after", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        // Recovery: sel captured fresh (reset cleared sel_q), n=1.
        drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        step_check("recover_init", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step_check("recover_load", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step_check("recover_run", 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        step_check("recover_done", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step_check("recover_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle sequencer that produces the 2-bit control code consumed by the datapath's control-word decoder. On a start request it steps through INIT, LOAD and a counted run of one selected operation, presenting one code per cycle with a valid qualifier, then signals completion. It sits between the top-level FSM/user inputs and the control decoder, replacing hand-driven code switches.

## Interface
- CNT_W, 4, width of the iteration count; max run length 2^CNT_W-1 cycles
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a sequence; sampled only in IDLE
- sel  in  1  operation select for RUN phase: 0 -> code 2'b10, 1 -> code 2'b11; captured with start
- n  in  CNT_W  number of RUN cycles; captured with start
- hold  in  1  stall: freezes state and counter while high
- abort  in  1  cancel the current sequence
- code  out  2  control code to the decoder
- valid  out  1  code is to be acted on this cycle
- busy  out  1  sequence in progress (INIT, LOAD, RUN)
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort

## Operation
- Reset: state IDLE; code=2'b00, valid=0, busy=0, done=0, aborted=0; sel_q=0, cnt=0.
- States: IDLE, INIT, LOAD, RUN, DONE, ABORT.
- IDLE: code=00, valid=0. start=1 -> capture sel_q<=sel, cnt<=n; next INIT. start=0 -> stay.
- INIT: code=00, valid=1; next LOAD.
- LOAD: code=01, valid=1; next RUN if cnt!=0, else DONE.
- RUN: code={1'b1, sel_q}, valid=1; cnt decrements each active cycle; when cnt==1 next DONE (exactly n RUN cycles).
- DONE: code=00, valid=0, done=1; next IDLE.
- ABORT: code=00, valid=0, aborted=1; next IDLE.
- busy=1 exactly in INIT, LOAD, RUN.
- hold=1 in INIT/LOAD/RUN: state, cnt unchanged; valid forced 0; code keeps its current value. hold has no effect in IDLE, DONE, ABORT.
- abort=1 in INIT/LOAD/RUN: next ABORT regardless of hold; no done pulse. abort in IDLE/DONE/ABORT ignored.
- start while not IDLE ignored (no queueing). start and abort in the same IDLE cycle: start wins (abort ignored in IDLE).
- cnt arithmetic: unsigned CNT_W bits, never decremented below 0; n=0 skips RUN.

## Timing
- All outputs are Moore functions of registered state/sel_q; no combinational input-to-output paths.
- Latency: start sampled at edge k -> INIT visible after edge k, i.e. first valid code one cycle after start.
- Total unstalled sequence: 2+n valid cycles, then 1 DONE cycle; busy high for 2+n cycles.
- Each hold cycle extends the sequence by exactly one cycle.
- abort sampled at edge k -> ABORT state after edge k, IDLE after edge k+1; next start accepted in the IDLE cycle after.
- Back-to-back: start held high through DONE is re-sampled in IDLE, giving one idle cycle between sequences.
- rst_n assertion mid-sequence forces reset values immediately, independent of clk.

## Structure
- Shared package: code constants CODE_INIT=2'b00, CODE_LOAD=2'b01, CODE_OPA=2'b10, CODE_OPB=2'b11; state encoding typedef (3 bits).
- Single module; the down-counter is simple enough to stay inline. Top level instantiates control_sequencer and feeds code into the existing control-word decoder.

## Test plan
- Reset then idle: rst_n low, start=0 -> code=00, valid=0, busy=0, done=0 for 10 cycles.
- Normal run: start=1, sel=0, n=3 -> valid codes 00,01,10,10,10 on 5 consecutive cycles, then done=1 for 1 cycle, busy high 5 cycles.
- Zero count: start, sel=1, n=0 -> codes 00,01 valid, then done; code 11 never appears.
- Hold: sel=1, n=2, hold high for 2 cycles during first RUN cycle -> valid=0 those 2 cycles, exactly two valid 11 codes total, done 2 cycles later than unstalled.
- Abort: n=5, abort asserted on second RUN cycle -> aborted=1 next cycle, done never pulses, IDLE after; new start then runs normally.
- Async reset mid-RUN: rst_n low between edges -> busy, valid drop to 0 immediately; start ignored while rst_n low.
